// File: rtl/pss_cp_insert_if.sv
// Sample stream bundle for the PSS cyclic-prefix inserter.
// Carries the IFFT-side input stream and the DAC/framing-side output stream.
// The slave modport is the inserter's view; the master modport is the view of
// whatever sources input samples and sinks output samples.
interface pss_cp_insert_if #(
   parameter int DW = 24
);
   logic [2*DW-1:0] data_in;
   logic            valid_in;
   logic            ready_out;
   logic [2*DW-1:0] data_out;
   logic            valid_out;
   logic            ready_in;
   logic            sop_out;
   logic            eop_out;

   modport master (
      output data_in, valid_in, ready_in,
      input  ready_out, data_out, valid_out, sop_out, eop_out
   );

   modport slave (
      input  data_in, valid_in, ready_in,
      output ready_out, data_out, valid_out, sop_out, eop_out
   );
endinterface

// File: rtl/pss_cp_insert.sv
// Cyclic-prefix inserter for the PSS transmit chain.
// Captures one N-sample IFFT symbol, then emits the last CP_LEN samples
// followed by the whole symbol as one contiguous OFDM symbol.
// Optional macro PSS_CP_PINGPONG_EN: two banks so the next symbol fills while
// the current one is read out; undefined builds a single bank.
module pss_cp_insert #(
   parameter int N      = 128,
   parameter int CP_LEN = 9,
   parameter int DW     = 24
) (
   input logic           clk,
   input logic           rst,
   pss_cp_insert_if.slave bus
);
   localparam int W  = 2 * DW;
   localparam int AW = $clog2(N);
`ifdef PSS_CP_PINGPONG_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif
   // First address read for a symbol: start of the prefix, or body start.
   localparam logic [AW-1:0] FIRST_ADDR = (CP_LEN == 0) ? '0 : AW'(N - CP_LEN);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);

   // ST_FILL doubles as "readout idle": it issues the first read of a symbol.
   typedef enum logic [1:0] {ST_FILL, ST_CP, ST_BODY} state_t;

   state_t          st_q, st_d;
   logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic            wr_bank_q, wr_bank_d;
   logic            rd_bank_q, rd_bank_d;
   logic [1:0]      full_q, full_d;
   logic            ready_q, ready_d;
   logic            valid_q, valid_d;
   logic            sop_q, sop_d;
   logic            eop_q, eop_d;
   logic [W-1:0]    data_q, data_d;
`ifdef PSS_CP_PINGPONG_EN
   logic            out_bank_q, out_bank_d;
`endif

   logic            accept;
   logic            fill_done;
   logic            load_ok;
   logic            bank_ready;
   logic            load;
   logic            cur_body;
   logic [AW-1:0]   cur_addr;
   logic [W-1:0]    rd_word;
   logic [W-1:0]    bank_sel_word;
   logic [NB-1:0][W-1:0] bank_word;

   assign accept    = bus.valid_in && ready_q;
   assign fill_done = accept && (wr_cnt_q == LAST_ADDR);
   assign load_ok   = !valid_q || bus.ready_in;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_bank
         logic [W-1:0] mem [N];
         // Symbol storage: one write port from the fill counter.
         always_ff @(posedge clk) begin
            if (accept && (wr_bank_q == 1'(gi))) begin
               mem[wr_cnt_q] <= bus.data_in;
            end
         end
         assign bank_word[gi] = mem[cur_addr];
      end
   endgenerate

`ifdef PSS_CP_PINGPONG_EN
   assign bank_sel_word = rd_bank_q ? bank_word[1] : bank_word[0];
`else
   assign bank_sel_word = bank_word[0];
`endif

   // Next-state: fill side, readout sequencing and output register.
   always_comb begin
      st_d      = st_q;
      wr_cnt_d  = wr_cnt_q;
      rd_addr_d = rd_addr_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      valid_d   = valid_q;
      data_d    = data_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
`ifdef PSS_CP_PINGPONG_EN
      out_bank_d = out_bank_q;
`endif
      cur_addr   = rd_addr_q;
      cur_body   = (st_q == ST_BODY);
      bank_ready = 1'b1;

      if (accept) begin
         wr_cnt_d = wr_cnt_q + AW'(1);
      end
      if (fill_done) begin
         full_d[wr_bank_q] = 1'b1;
`ifdef PSS_CP_PINGPONG_EN
         wr_bank_d = ~wr_bank_q;
`endif
      end

      // Idle readout starts as soon as a bank is complete, including the
      // very cycle its last sample arrives, so valid follows that accept.
      if (st_q == ST_FILL) begin
         cur_addr   = FIRST_ADDR;
         cur_body   = (CP_LEN == 0);
         bank_ready = full_q[rd_bank_q] || (fill_done && (wr_bank_q == rd_bank_q));
      end
      load = load_ok && bank_ready;

      // The sample being written this cycle is not in the array yet.
      if (accept && (wr_bank_q == rd_bank_q) && (wr_cnt_q == cur_addr)) begin
         rd_word = bus.data_in;
      end else begin
         rd_word = bank_sel_word;
      end

      if (valid_q && bus.ready_in) begin
         valid_d = 1'b0;
`ifdef PSS_CP_PINGPONG_EN
         if (eop_q) begin
            full_d[out_bank_q] = 1'b0;
         end
`endif
      end

      if (load) begin
         valid_d = 1'b1;
         data_d  = rd_word;
         sop_d   = (st_q == ST_FILL);
         eop_d   = cur_body && (cur_addr == LAST_ADDR);
`ifdef PSS_CP_PINGPONG_EN
         out_bank_d = rd_bank_q;
`endif
         if (cur_addr == LAST_ADDR) begin
            rd_addr_d = '0;
            if (cur_body) begin
               st_d = ST_FILL;
`ifdef PSS_CP_PINGPONG_EN
               rd_bank_d = ~rd_bank_q;
`else
               full_d[0] = 1'b0;
`endif
            end else begin
               st_d = ST_BODY;
            end
         end else begin
            st_d      = cur_body ? ST_BODY : ST_CP;
            rd_addr_d = cur_addr + AW'(1);
         end
      end

`ifdef PSS_CP_PINGPONG_EN
      ready_d = !full_d[wr_bank_d];
`else
      // Hold off one extra cycle after release so the bank is never
      // re-accepted in the cycle its final sample is being loaded.
      ready_d = !full_d[0] && !full_q[0];
`endif
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= ST_FILL;
         wr_cnt_q  <= '0;
         rd_addr_q <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
`ifdef PSS_CP_PINGPONG_EN
         out_bank_q <= 1'b0;
`endif
      end else begin
         st_q      <= st_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_addr_q <= rd_addr_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
`ifdef PSS_CP_PINGPONG_EN
         out_bank_q <= out_bank_d;
`endif
      end
   end

   assign bus.ready_out = ready_q;
   assign bus.valid_out = valid_q;
   assign bus.data_out  = data_q;
   assign bus.sop_out   = sop_q;
   assign bus.eop_out   = eop_q;
endmodule

// File: tb/tb_pss_cp_insert.sv
// Bench for pss_cp_insert: one CP_LEN=9 instance and one CP_LEN=0 instance.
// Expected beats come from a queue model built straight from the CP rule
// (last CP samples, then the full symbol), checked on every output transfer.
module tb_pss_cp_insert;
   localparam int N  = 128;
   localparam int CP = 9;
   localparam int DW = 24;
   localparam int W  = 2 * DW;

   typedef struct packed {
      logic [W-1:0] d;
      logic         s;
      logic         e;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pss_cp_insert_if #(.DW(DW)) if9 ();
   pss_cp_insert_if #(.DW(DW)) if0 ();

   pss_cp_insert #(.N(N), .CP_LEN(CP), .DW(DW)) dut9 (.clk(clk), .rst(rst), .bus(if9));
   pss_cp_insert #(.N(N), .CP_LEN(0),  .DW(DW)) dut0 (.clk(clk), .rst(rst), .bus(if0));

   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t q9[$];
   beat_t q0[$];
   int    x9 = 0, x0 = 0;
   int    run9 = 0, maxrun9 = 0;
   logic  rnd_mode = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] samp(input int v);
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      re = DW'(v);
      im = DW'(-v);
      return {im, re};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: a symbol of samples base+k produces its last cp samples, then all N.
   task automatic build(input int which, input int base);
      int    cp;
      beat_t b;
      cp = (which == 9) ? CP : 0;
      for (int i = 0; i < N + cp; i++) begin
         int idx;
         idx = (i < cp) ? (N - cp + i) : (i - cp);
         b.d = samp(base + idx);
         b.s = (i == 0);
         b.e = (i == N + cp - 1);
         if (which == 9) q9.push_back(b);
         else q0.push_back(b);
      end
   endtask

   task automatic drive(input int which, input logic v, input logic [W-1:0] d);
      if (which == 9) begin
         if9.valid_in = v;
         if9.data_in  = d;
      end else begin
         if0.valid_in = v;
         if0.data_in  = d;
      end
   endtask

   // Feeds N samples; with junk set, valid_in stays high with garbage while
   // ready_out is low. waits counts cycles spent with ready_out low.
   task automatic send_sym(input int which, input int base, input logic junk,
                           output int waits, output logic seen_valid);
      int   k;
      int   guard;
      logic rdy;
      k = 0;
      guard = 0;
      waits = 0;
      seen_valid = 1'b0;
      while (k < N && guard < 4000) begin
         rdy = (which == 9) ? if9.ready_out : if0.ready_out;
         if (((which == 9) ? if9.valid_out : if0.valid_out) === 1'b1) seen_valid = 1'b1;
         if (rdy) begin
            drive(which, 1'b1, samp(base + k));
            k++;
         end else begin
            if (junk) drive(which, 1'b1, 48'hDE0000_000000 | W'(guard));
            else drive(which, 1'b0, '0);
            waits++;
         end
         step();
         guard++;
      end
      chk("send_complete", 64'(k), 64'(N));
      if (junk) drive(which, 1'b1, 48'hDEAD00_00BEEF);
      else drive(which, 1'b0, '0);
   endtask

   task automatic drain(input int which);
      int g;
      g = 0;
      while (g < 3000 && ((which == 9) ? (q9.size() != 0 || if9.valid_out) :
                                         (q0.size() != 0 || if0.valid_out))) begin
         step();
         g++;
      end
      chk((which == 9) ? "drain9" : "drain0", 64'(g < 3000), 64'd1);
   endtask

   // Downstream ready for the CP_LEN=9 instance.
   initial begin
      if9.ready_in = 1'b1;
      if0.ready_in = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if9.ready_in = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Checker for the CP_LEN=9 instance: stall stability and beat order.
   initial begin
      beat_t        e;
      logic         stall;
      logic [W-1:0] pd;
      logic         ps, pe;
      stall = 1'b0;
      pd = '0;
      ps = 1'b0;
      pe = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
            run9  = 0;
         end else begin
            if (stall) begin
               chk("stall_valid9", 64'(if9.valid_out), 64'd1);
               chk("stall_data9", 64'(if9.data_out), 64'(pd));
               chk("stall_sop9", 64'(if9.sop_out), 64'(ps));
               chk("stall_eop9", 64'(if9.eop_out), 64'(pe));
            end
            if (if9.valid_out && if9.ready_in) begin
               $display("[TB] u9 beat %0d data=%h sop=%b eop=%b", x9, if9.data_out, if9.sop_out, if9.eop_out);
               chk("beat_avail9", 64'(q9.size() > 0), 64'd1);
               if (q9.size() > 0) begin
                  e = q9.pop_front();
                  chk("beat_data9", 64'(if9.data_out), 64'(e.d));
                  chk("beat_sop9", 64'(if9.sop_out), 64'(e.s));
                  chk("beat_eop9", 64'(if9.eop_out), 64'(e.e));
               end
               x9++;
               run9++;
               if (run9 > maxrun9) maxrun9 = run9;
            end else begin
               run9 = 0;
            end
            stall = if9.valid_out && !if9.ready_in;
            pd = if9.data_out;
            ps = if9.sop_out;
            pe = if9.eop_out;
         end
      end
   end

   // Checker for the CP_LEN=0 instance.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst && if0.valid_out && if0.ready_in) begin
            $display("[TB] u0 beat %0d data=%h sop=%b eop=%b", x0, if0.data_out, if0.sop_out, if0.eop_out);
            chk("beat_avail0", 64'(q0.size() > 0), 64'd1);
            if (q0.size() > 0) begin
               e = q0.pop_front();
               chk("beat_data0", 64'(if0.data_out), 64'(e.d));
               chk("beat_sop0", 64'(if0.sop_out), 64'(e.s));
               chk("beat_eop0", 64'(if0.eop_out), 64'(e.e));
            end
            x0++;
         end
      end
   end

   initial begin
      int   w, start, g;
      logic sv;
      drive(9, 1'b0, '0);
      drive(0, 1'b0, '0);
      repeat (3) step();
      @(negedge clk);
      chk("rst_ready", 64'(if9.ready_out), 64'd0);
      chk("rst_valid", 64'(if9.valid_out), 64'd0);
      chk("rst_data", 64'(if9.data_out), 64'd0);
      chk("rst_sop", 64'(if9.sop_out), 64'd0);
      chk("rst_eop", 64'(if9.eop_out), 64'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_in_release_cycle", 64'(if9.ready_out), 64'd0);
      step();
      @(negedge clk);
      chk("ready_after_release", 64'(if9.ready_out), 64'd1);
      step();

      // One symbol, ready_in high.
      build(9, 0);
      chk("pin_len", 64'(q9.size()), 64'd137);
      chk("pin_first", 64'(q9[0].d), 64'h0000_FFFF89_000077);
      chk("pin_body0", 64'(q9[9].d), 64'd0);
      chk("pin_last", 64'(q9[136].d), 64'h0000_FFFF81_00007F);
      start = x9;
      send_sym(9, 0, 1'b0, w, sv);
      chk("t1_no_early_valid", 64'(sv), 64'd0);
      @(negedge clk);
      chk("t1_latency_valid", 64'(if9.valid_out), 64'd1);
      chk("t1_first_data", 64'(if9.data_out), 64'h0000_FFFF89_000077);
      chk("t1_first_sop", 64'(if9.sop_out), 64'd1);
      drain(9);
      chk("t1_beats", 64'(x9 - start), 64'd137);

      // Same symbol, random ready_in.
      rnd_mode = 1'b1;
      build(9, 0);
      start = x9;
      send_sym(9, 0, 1'b0, w, sv);
      drain(9);
      chk("t2_beats", 64'(x9 - start), 64'd137);
      rnd_mode = 1'b0;
      repeat (2) step();

      // Three back-to-back symbols, valid_in held high with junk data.
      maxrun9 = 0;
      start = x9;
      for (int s = 0; s < 3; s++) begin
         build(9, 1000 * (s + 1));
         send_sym(9, 1000 * (s + 1), 1'b1, w, sv);
`ifndef PSS_CP_PINGPONG_EN
         if (s > 0) chk("t3_ready_low_gap", 64'(w >= 137), 64'd1);
`endif
      end
      drain(9);
      drive(9, 1'b0, '0);
      chk("t3_beats", 64'(x9 - start), 64'd411);
`ifdef PSS_CP_PINGPONG_EN
      chk("t3_gapless_run", 64'(maxrun9 >= 411), 64'd1);
`endif
      repeat (2) step();

      // Reset at output beat 50.
      build(9, 5000);
      start = x9;
      send_sym(9, 5000, 1'b0, w, sv);
      g = 0;
      while ((x9 - start) < 50 && g < 1000) begin
         step();
         g++;
      end
      chk("t4_reach_beat50", 64'(x9 - start), 64'd50);
      rst = 1'b1;
      q9.delete();
      step();
      @(negedge clk);
      chk("t4_valid", 64'(if9.valid_out), 64'd0);
      chk("t4_data", 64'(if9.data_out), 64'd0);
      chk("t4_sop", 64'(if9.sop_out), 64'd0);
      chk("t4_eop", 64'(if9.eop_out), 64'd0);
      chk("t4_ready_in_rst", 64'(if9.ready_out), 64'd0);
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      chk("t4_ready_release", 64'(if9.ready_out), 64'd1);
      start = x9;
      repeat (200) step();
      chk("t4_no_stale_beats", 64'(x9 - start), 64'd0);
      build(9, 7000);
      send_sym(9, 7000, 1'b0, w, sv);
      drain(9);
      chk("t4_fresh_beats", 64'(x9 - start), 64'd137);

      // CP_LEN = 0 instance.
      build(0, 0);
      chk("pin0_len", 64'(q0.size()), 64'd128);
      chk("pin0_last", 64'(q0[127].d), 64'h0000_FFFF81_00007F);
      start = x0;
      send_sym(0, 0, 1'b0, w, sv);
      @(negedge clk);
      chk("t5_first_data", 64'(if0.data_out), 64'd0);
      chk("t5_first_sop", 64'(if0.sop_out), 64'd1);
      drain(0);
      chk("t5_beats", 64'(x0 - start), 64'd128);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pss_cp_insert.md
Name: pss_cp_insert

Overview:
Cyclic-prefix inserter that sits directly downstream of the 128-point IFFT in the PSS transmit chain.
- Buffers one N-sample time-domain symbol. Input word is {imag[47:24], real[23:0]}.
- Replays the last CP_LEN samples, then the full symbol, as one contiguous OFDM symbol with a ready/valid handshake toward the DAC/framing stage.

Parameters:
N, 128, samples per symbol (IFFT size); power of two.
CP_LEN, 9, cyclic-prefix length in samples; legal range 0..N-1.
DW, 24, bits per real/imag component; word width is 2*DW.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
data_in  in  2*DW  IFFT sample, {imag[2*DW-1:DW], real[DW-1:0]}.
valid_in  in  1  data_in valid.
ready_out  out  1  block can accept a sample.
data_out  out  2*DW  output sample, same packing as data_in.
valid_out  out  1  data_out valid.
ready_in  in  1  downstream accepts data_out.
sop_out  out  1  high with the first CP sample (or the first body sample when CP_LEN=0).
eop_out  out  1  high with the last body sample (index N-1).

Behaviour:
- Reset values: ready_out=0, valid_out=0, data_out=0, sop_out=0, eop_out=0. State=FILL, all counters 0. ready_out rises the cycle after rst deasserts.
- Transfers:
  - Input accept = valid_in && ready_out.
  - Output transfer = valid_out && ready_in.
- Storage: N x 2*DW register array; write address = fill counter (0..N-1).
- State FILL:
  - ready_out=1.
  - Each accept writes mem[wr_cnt] and increments wr_cnt.
  - On the accept with wr_cnt==N-1: wr_cnt wraps to 0 and the state moves to CP, or to BODY if CP_LEN==0.
- State CP:
  - ready_out=0.
  - Read address runs N-CP_LEN .. N-1.
  - After the last CP sample is loaded into the output register, move to BODY with read address 0.
- State BODY:
  - ready_out=0.
  - Read address runs 0 .. N-1.
  - After index N-1 is loaded, return to FILL.
- Output register:
  - Loads when (!valid_out || ready_in) and a read is pending in CP or BODY. data_out = mem[rd_addr].
  - valid_out=1 after a load. It clears when a transfer occurs and no new load happens in the same cycle.
  - data_out, sop_out and eop_out hold stable while valid_out && !ready_in.
- Latency: the first valid_out is asserted the cycle after the N-th input accept.
- Throughput: with ready_in held high, N+CP_LEN consecutive valid beats.
- Output count per symbol: exactly N+CP_LEN beats, with no drop or duplicate under any ready_in pattern.
- valid_in asserted while ready_out=0 is ignored; data is not captured.
- Reset asserted mid-symbol:
  - The next cycle is in FILL with all outputs at their reset values.
  - The partial symbol is discarded and no further output beats occur for it.
- Widths: pure data movement; no arithmetic or rescaling.

Optional Feature:
Macro: PSS_CP_PINGPONG_EN
- Defined:
  - Two N-word banks with a write-bank pointer and a read-bank pointer, plus a full flag per bank.
  - Filling one bank proceeds concurrently with CP/BODY readout of the other.
  - ready_out=1 whenever the current write bank is not full.
  - A bank's full flag clears the cycle after its last body sample transfers.
  - If fill-complete and read-complete happen in the same cycle, both take effect with no lost cycle.
  - With continuous input and ready_in=1, output is gapless across symbols.
- Undefined: single bank; ready_out=0 from fill completion until the last body sample is loaded, exactly as in Behaviour.

Test Plan:
1. One symbol, real=k, imag=-k for k=0..127, CP_LEN=9, ready_in=1 -> 137 beats with real 119..127 then 0..127. sop_out on beat 0, eop_out on beat 136, first valid_out 1 cycle after the 128th accept.
2. Same stimulus, ready_in random at 50% -> identical 137-beat sequence. data_out/sop/eop stable during every stall; no drops or duplicates.
3. Three back-to-back symbols:
   - Single bank: ready_out=0 for at least 137 cycles between fills.
   - With PSS_CP_PINGPONG_EN: 411 consecutive output beats with ready_in=1, no gap.
4. rst pulsed at output beat 50 of a symbol -> next cycle valid_out=0, data_out=0, ready_out=1 after release. A fresh symbol is then output correctly.
5. CP_LEN=0 -> 128 beats, real 0..127, with sop_out and eop_out on beats 0 and 127.
6. valid_in held high while ready_out=0 with changing data -> the ignored samples never appear on data_out.
